// File: rtl/adder_nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and
// the width of the time-shared adder slice.
package adder_nibble_serial_pkg;

    // Width of one adder pass; the operands are processed in slices of this size.
    localparam int NIB_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : adder_nibble_serial_pkg

// File: rtl/adder_nibble_serial_adder_4bit.sv
// Combinational 4-bit ripple-carry adder slice, time-shared by the
// nibble-serial controller. Built from a chain of full-adder cells.
module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);

    // carry_w[k] is the carry into bit k; carry_w[4] is the slice carry-out.
    logic [4:0] carry_w;

    assign carry_w[0] = i_c;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign o_s[gi]         = i_a[gi] ^ i_b[gi] ^ carry_w[gi];
            assign carry_w[gi + 1] = (i_a[gi] & i_b[gi])
                                   | (i_a[gi] & carry_w[gi])
                                   | (i_b[gi] & carry_w[gi]);
        end
    endgenerate

    assign o_c = carry_w[4];

endmodule : adder_4bit

// File: rtl/adder_nibble_serial.sv
// Area-minimal wide adder: one 4-bit adder slice is reused N_NIB times,
// LSB nibble first, with the inter-nibble carry held in a register.
// Operands enter through a valid/ready handshake; {o_c, o_s} is returned
// through a second valid/ready handshake and held until the next accept.
module adder_nibble_serial
    import adder_nibble_serial_pkg::*;
#(
    parameter  int N_NIB = 4,
    localparam int W     = NIB_W * N_NIB
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_s,
    output logic         o_c,
    output logic         o_busy
);

    // A single-nibble build still needs a 1-bit index register.
    localparam int                IDX_W    = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_NIB - 1);

    state_e             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       s_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               c_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;

    // Operands shifted so that the active nibble sits at the bottom.
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_s;
    logic               nib_co;

    // Result register with the active nibble replaced by the slice sum.
    logic [W-1:0]       s_d;

    assign a_sh  = a_q >> {idx_q, 2'b00};
    assign b_sh  = b_q >> {idx_q, 2'b00};
    assign nib_a = a_sh[NIB_W-1:0];
    assign nib_b = b_sh[NIB_W-1:0];

    adder_4bit u_adder_4bit (
        .i_a (nib_a),
        .i_b (nib_b),
        .i_c (carry_q),
        .o_s (nib_s),
        .o_c (nib_co)
    );

    // Per-nibble write steering: only the slice addressed by idx_q changes.
    generate
        for (genvar gi = 0; gi < N_NIB; gi++) begin : g_snib
            assign s_d[gi*NIB_W +: NIB_W] = (idx_q == IDX_W'(gi))
                                          ? nib_s
                                          : s_q[gi*NIB_W +: NIB_W];
        end
    endgenerate

    // Controller FSM with registered handshake, status and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (i_in_valid && in_ready_q) begin
                        a_q        <= i_a;
                        b_q        <= i_b;
                        carry_q    <= i_c;
                        idx_q      <= '0;
                        s_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    s_q     <= s_d;
                    carry_q <= nib_co;
                    if (idx_q == IDX_LAST) begin
                        // Last slice: its carry-out is the result carry.
                        c_q         <= nib_co;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Result stays valid and stable until the consumer takes it.
                    if (i_out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_s         = s_q;
    assign o_c         = c_q;
    assign o_busy      = busy_q;

endmodule : adder_nibble_serial

// File: tb/tb_adder_nibble_serial.sv
// Self-checking bench for adder_nibble_serial: directed scenarios on a
// 4-nibble build plus a 1-nibble build, and a randomized back-to-back run
// checked against plain W+1-bit arithmetic.
module tb_adder_nibble_serial;

    logic        clk;
    logic        i_rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        i_c;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [15:0] o_s;
    logic        o_c;
    logic        o_busy;

    logic        n1_in_valid;
    logic        n1_in_ready;
    logic [3:0]  n1_a;
    logic [3:0]  n1_b;
    logic        n1_c;
    logic        n1_out_valid;
    logic        n1_out_ready;
    logic [3:0]  n1_s;
    logic        n1_co;
    logic        n1_busy;

    int errors = 0;
    int checks = 0;

    adder_nibble_serial #(.N_NIB(4)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_c         (i_c),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_s         (o_s),
        .o_c         (o_c),
        .o_busy      (o_busy)
    );

    adder_nibble_serial #(.N_NIB(1)) dut_n1 (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_in_valid  (n1_in_valid),
        .o_in_ready  (n1_in_ready),
        .i_a         (n1_a),
        .i_b         (n1_b),
        .i_c         (n1_c),
        .o_out_valid (n1_out_valid),
        .i_out_ready (n1_out_ready),
        .o_s         (n1_s),
        .o_c         (n1_co),
        .o_busy      (n1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision sum, no truncation.
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; ok=0 if never accepted within the bound.
    task automatic send(input logic [15:0] a_v, input logic [15:0] b_v, input logic c_v,
                        output bit ok);
        bit rdy;
        ok = 1'b0;
        i_a = a_v;
        i_b = b_v;
        i_c = c_v;
        i_in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            rdy = o_in_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        i_in_valid = 1'b0;
        // Scramble operands after the accept; they must have no effect.
        i_a = 16'($urandom);
        i_b = 16'($urandom);
        i_c = 1'($urandom);
    endtask

    // Count edges until o_out_valid is seen (999 if it never appears).
    task automatic wait_valid(output int n);
        n = 999;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (o_out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_out_valid); end
        checks++; if (o_s !== 16'h0) begin errors++; $display("FAIL reset_s got=%h exp=0000", o_s); end
        checks++; if (o_c !== 1'b0) begin errors++; $display("FAIL reset_c got=%b exp=0", o_c); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        i_rst = 1'b0;
        tick();
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_in_ready); end
        checks++; if (n1_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_n1 got=%b exp=1", n1_in_ready); end
        $display("reset done");
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        i_out_ready = 1'b1;
        send(16'h1234, 16'h1111, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept got=timeout exp=accept"); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", o_busy); end
        wait_valid(n);
        checks++; if (n != 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", n); end
        checks++; if ({o_c, o_s} !== 17'h02345) begin errors++; $display("FAIL basic_sum got=%b_%h exp=0_2345", o_c, o_s); end
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done got=%b exp=0", o_in_ready); end
        tick();
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", o_out_valid); end
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%b exp=1", o_in_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", o_busy); end
        $display("basic a=1234 b=1111 c=0 -> c=%b s=%h", o_c, o_s);
    endtask

    task automatic test_full_ripple();
        bit ok;
        int n;
        logic [15:0] av [2];
        logic [15:0] bv [2];
        logic [16:0] ev;
        av[0] = 16'hFFFF; bv[0] = 16'h0000;
        av[1] = 16'hFFFF; bv[1] = 16'hFFFF;
        i_out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            ev = ref_sum(av[t], bv[t], 1'b1);
            send(av[t], bv[t], 1'b1, ok);
            wait_valid(n);
            checks++;
            if (!ok || n != 4 || {o_c, o_s} !== ev) begin
                errors++;
                $display("FAIL ripple_%0d got=%b_%h lat=%0d exp=%b_%h lat=4", t, o_c, o_s, n, ev[16], ev[15:0]);
            end
            $display("ripple a=%h b=%h c=1 -> c=%b s=%h", av[t], bv[t], o_c, o_s);
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        i_out_ready = 1'b0;
        send(16'h00F0, 16'h0010, 1'b0, ok);
        wait_valid(n);
        checks++; if (!ok || n != 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", n); end
        i_in_valid = 1'b1;
        i_a = 16'hAAAA;
        i_b = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (o_out_valid !== 1'b1 || {o_c, o_s} !== 17'h00100 || o_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got=v%b s=%h c=%b rdy=%b exp=v1 s=0100 c=0 rdy=0",
                         k, o_out_valid, o_s, o_c, o_in_ready);
            end
        end
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        tick();
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", o_out_valid); end
        checks++; if (o_s !== 16'h0100 || o_busy !== 1'b0) begin errors++; $display("FAIL bp_not_captured got=s%h busy%b exp=s0100 busy0", o_s, o_busy); end
        $display("backpressure a=00f0 b=0010 c=0 -> s=%h", o_s);
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int n;
        i_out_ready = 1'b1;
        send(16'h8888, 16'h8888, 1'b1, ok);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_s !== 16'h0 || o_c !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got=v%b s=%h c=%b busy=%b exp=v0 s=0000 c=0 busy=0",
                     o_out_valid, o_s, o_c, o_busy);
        end
        tick();
        checks++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ready got=rdy%b v%b exp=rdy1 v0", o_in_ready, o_out_valid); end
        send(16'h0001, 16'h0001, 1'b0, ok);
        wait_valid(n);
        checks++;
        if (!ok || n != 4 || {o_c, o_s} !== 17'h00002) begin
            errors++;
            $display("FAIL midrst_next got=%b_%h lat=%0d exp=0_0002 lat=4", o_c, o_s, n);
        end
        $display("reset-mid-op then a=0001 b=0001 c=0 -> c=%b s=%h", o_c, o_s);
        tick();
    endtask

    task automatic test_nib1();
        int n;
        bit ok;
        bit rdy;
        ok = 1'b0;
        n1_out_ready = 1'b1;
        n1_a = 4'hF;
        n1_b = 4'h1;
        n1_c = 1'b0;
        n1_in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rdy = n1_in_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        n1_in_valid = 1'b0;
        n1_a = 4'h3;
        n = 999;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (n1_out_valid) begin
                n = k;
                break;
            end
        end
        checks++; if (!ok || n != 1) begin errors++; $display("FAIL nib1_latency got=%0d exp=1", n); end
        checks++; if ({n1_co, n1_s} !== 5'b1_0000) begin errors++; $display("FAIL nib1_sum got=%b_%h exp=1_0", n1_co, n1_s); end
        $display("nib1 a=f b=1 c=0 -> c=%b s=%h", n1_co, n1_s);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_q[$];
        int got;
        int sent;
        got = 0;
        sent = 0;
        i_out_ready = 1'b0;
        fork
            begin : driver
                bit ok;
                logic [15:0] a_v;
                logic [15:0] b_v;
                logic        c_v;
                for (int i = 0; i < 1000; i++) begin
                    a_v = 16'($urandom);
                    b_v = 16'($urandom);
                    c_v = 1'($urandom_range(0, 1));
                    send(a_v, b_v, c_v, ok);
                    if (!ok) begin
                        errors++;
                        $display("FAIL rand_accept op=%0d got=timeout exp=accept", i);
                        break;
                    end
                    exp_q.push_back(ref_sum(a_v, b_v, c_v));
                    sent++;
                    $display("op %0d a=%h b=%h c=%b", i, a_v, b_v, c_v);
                end
            end
            begin : monitor
                logic [16:0] ev;
                for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
                    tick();
                    checks++;
                    if (o_in_ready && (o_busy || o_out_valid)) begin
                        errors++;
                        $display("FAIL rand_ready_outside_idle got=rdy1 busy%b v%b exp=rdy0", o_busy, o_out_valid);
                    end
                    if (o_out_valid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_duplicate got=c%b s%h exp=no result", o_c, o_s);
                        end else begin
                            ev = exp_q[0];
                            if ({o_c, o_s} !== ev) begin
                                errors++;
                                $display("FAIL rand_sum res=%0d got=%b_%h exp=%b_%h", got, o_c, o_s, ev[16], ev[15:0]);
                            end
                        end
                        i_out_ready = ($urandom_range(0, 3) != 0);
                        if (i_out_ready && exp_q.size() != 0) begin
                            void'(exp_q.pop_front());
                            got++;
                        end
                    end else begin
                        i_out_ready = 1'($urandom_range(0, 1));
                    end
                end
            end
        join
        tick();
        i_out_ready = 1'b1;
        checks++; if (got != 1000 || sent != 1000) begin errors++; $display("FAIL rand_count got=%0d sent=%0d exp=1000", got, sent); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
        $display("random ops sent=%0d received=%0d", sent, got);
    endtask

    initial begin
        i_rst = 1'b1;
        i_in_valid = 1'b0;
        i_a = '0;
        i_b = '0;
        i_c = 1'b0;
        i_out_ready = 1'b0;
        n1_in_valid = 1'b0;
        n1_a = '0;
        n1_b = '0;
        n1_c = 1'b0;
        n1_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_ripple();
        test_backpressure();
        test_reset_mid_op();
        test_nib1();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_adder_nibble_serial
